// File: rtl/sd_spi_multisec_test.sv
// SD-over-SPI multi-sector self-test sequencer.
// Writes SEC_CNT consecutive sectors with a known word pattern through the
// SD write engine, reads them back through the read engine and counts every
// word that does not match. Exposes done / err_cnt / error_flag for LEDs and
// supports re-running the test from DONE with a single test_start pulse.
module sd_spi_multisec_test #(
    parameter int          DATA_W        = 16,
    parameter int          WORDS_PER_SEC = 256,
    parameter int          SEC_CNT       = 4,
    parameter logic [31:0] START_ADDR    = 32'd2000,
    parameter int          PATTERN       = 0
) (
    input  logic              clk_50m,
    input  logic              reset_n,
    input  logic              sd_init_done,
    input  logic              test_start,
    input  logic              wr_busy,
    input  logic              wr_req,
    output logic              wr_start_en,
    output logic [31:0]       wr_sec_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic              rd_busy,
    input  logic              rd_en,
    input  logic [DATA_W-1:0] rd_data,
    output logic              rd_start_en,
    output logic [31:0]       rd_sec_addr,
    output logic              done,
    output logic [15:0]       err_cnt,
    output logic              error_flag
);

    localparam int TOTAL = SEC_CNT * WORDS_PER_SEC;
    localparam int IDX_W = $clog2(TOTAL + 1);
    localparam int SEC_W = $clog2(SEC_CNT + 1);

    localparam logic              PAT_INV   = (PATTERN != 0);
    localparam logic [IDX_W-1:0]  TOTAL_IDX = IDX_W'(TOTAL);
    localparam logic [IDX_W-1:0]  IDX_ONE   = IDX_W'(1);
    localparam logic [SEC_W-1:0]  LAST_SEC  = SEC_W'(SEC_CNT - 1);
    localparam logic [SEC_W-1:0]  SEC_ONE   = SEC_W'(1);
    localparam logic [15:0]       ERR_MAX   = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_START = 3'd1,
        WR_WAIT  = 3'd2,
        RD_START = 3'd3,
        RD_WAIT  = 3'd4,
        DONE     = 3'd5
    } state_t;

    state_t state_reg, state_next;

    // Input history for edge detection
    logic init_d1_reg, init_d2_reg;
    logic wr_busy_q_reg, rd_busy_q_reg;

    // Run counters
    logic [IDX_W-1:0] wr_idx_reg,  wr_idx_next;
    logic [IDX_W-1:0] rd_idx_reg,  rd_idx_next;
    logic [SEC_W-1:0] sec_idx_reg, sec_idx_next;
    logic [15:0]      err_cnt_reg, err_cnt_next;
    logic             err_inc;

    // Registered outputs
    logic        wr_start_en_reg, wr_start_en_next;
    logic        rd_start_en_reg, rd_start_en_next;
    logic [31:0] wr_sec_addr_reg, wr_sec_addr_next;
    logic [31:0] rd_sec_addr_reg, rd_sec_addr_next;
    logic        done_reg, done_next;

    // Derived events
    logic              init_rise;
    logic              wr_fall;
    logic              rd_fall;
    logic              abort;
    logic              last_sec;
    logic [31:0]       sec_addr;
    logic [DATA_W-1:0] wr_pat;
    logic [DATA_W-1:0] rd_pat;

    assign init_rise = init_d1_reg & ~init_d2_reg;
    assign wr_fall   = wr_busy_q_reg & ~wr_busy;
    assign rd_fall   = rd_busy_q_reg & ~rd_busy;
    // Losing card init anywhere outside IDLE kills the run immediately.
    assign abort     = (state_reg != IDLE) && !init_d1_reg;
    assign last_sec  = (sec_idx_reg == LAST_SEC);
    // Address arithmetic deliberately wraps modulo 2^32.
    assign sec_addr  = START_ADDR + 32'(sec_idx_reg);

    // Pattern words: the index is zero-extended (or truncated) to DATA_W and
    // optionally inverted. Bits above the index width are pure pattern bits.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_pat
            if (gi < IDX_W) begin : g_idx
                assign wr_pat[gi] = wr_idx_reg[gi] ^ PAT_INV;
                assign rd_pat[gi] = rd_idx_reg[gi] ^ PAT_INV;
            end else begin : g_pad
                assign wr_pat[gi] = PAT_INV;
                assign rd_pat[gi] = PAT_INV;
            end
        end
    endgenerate

    // Capture init level twice and busy lines once for edge detection
    always_ff @(posedge clk_50m) begin
        if (!reset_n) begin
            init_d1_reg   <= 1'b0;
            init_d2_reg   <= 1'b0;
            wr_busy_q_reg <= 1'b0;
            rd_busy_q_reg <= 1'b0;
        end else begin
            init_d1_reg   <= sd_init_done;
            init_d2_reg   <= init_d1_reg;
            wr_busy_q_reg <= wr_busy;
            rd_busy_q_reg <= rd_busy;
        end
    end

    // FSM state register
    always_ff @(posedge clk_50m) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state logic: start states last one cycle, waits end on busy fall
    always_comb begin
        state_next = state_reg;
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (init_rise) begin
                        state_next = WR_START;
                    end
                end
                WR_START: begin
                    state_next = WR_WAIT;
                end
                WR_WAIT: begin
                    if (wr_fall) begin
                        state_next = last_sec ? RD_START : WR_START;
                    end
                end
                RD_START: begin
                    state_next = RD_WAIT;
                end
                RD_WAIT: begin
                    if (rd_fall) begin
                        state_next = last_sec ? DONE : RD_START;
                    end
                end
                DONE: begin
                    if (test_start) begin
                        state_next = WR_START;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // FSM outputs: start pulses and sector addresses are issued one cycle after entering a start state
    always_comb begin
        wr_start_en_next = 1'b0;
        rd_start_en_next = 1'b0;
        wr_sec_addr_next = wr_sec_addr_reg;
        rd_sec_addr_next = rd_sec_addr_reg;
        done_next        = (state_next == DONE);
        if (abort) begin
            wr_sec_addr_next = 32'd0;
            rd_sec_addr_next = 32'd0;
        end else if (state_reg == WR_START) begin
            wr_start_en_next = 1'b1;
            wr_sec_addr_next = sec_addr;
        end else if (state_reg == RD_START) begin
            rd_start_en_next = 1'b1;
            rd_sec_addr_next = sec_addr;
        end
    end

    // Output registers
    always_ff @(posedge clk_50m) begin
        if (!reset_n) begin
            wr_start_en_reg <= 1'b0;
            rd_start_en_reg <= 1'b0;
            wr_sec_addr_reg <= 32'd0;
            rd_sec_addr_reg <= 32'd0;
            done_reg        <= 1'b0;
        end else begin
            wr_start_en_reg <= wr_start_en_next;
            rd_start_en_reg <= rd_start_en_next;
            wr_sec_addr_reg <= wr_sec_addr_next;
            rd_sec_addr_reg <= rd_sec_addr_next;
            done_reg        <= done_next;
        end
    end

    // Counter update: word indices run across the whole test, not per sector
    always_comb begin
        wr_idx_next  = wr_idx_reg;
        rd_idx_next  = rd_idx_reg;
        sec_idx_next = sec_idx_reg;
        err_cnt_next = err_cnt_reg;
        err_inc      = 1'b0;
        if (abort) begin
            wr_idx_next  = '0;
            rd_idx_next  = '0;
            sec_idx_next = '0;
            err_cnt_next = 16'd0;
        end else begin
            case (state_reg)
                WR_WAIT: begin
                    // Saturate so a misbehaving engine cannot run the pattern on.
                    if (wr_req && (wr_idx_reg != TOTAL_IDX)) begin
                        wr_idx_next = wr_idx_reg + IDX_ONE;
                    end
                    if (wr_fall) begin
                        // Read phase starts again from sector 0.
                        sec_idx_next = last_sec ? '0 : sec_idx_reg + SEC_ONE;
                    end
                end
                RD_WAIT: begin
                    if (rd_en) begin
                        if (rd_idx_reg == TOTAL_IDX) begin
                            // More words returned than were ever written.
                            err_inc = 1'b1;
                        end else begin
                            err_inc     = (rd_data != rd_pat);
                            rd_idx_next = rd_idx_reg + IDX_ONE;
                        end
                    end
                    if (rd_fall && !last_sec) begin
                        sec_idx_next = sec_idx_reg + SEC_ONE;
                    end
                end
                DONE: begin
                    if (test_start) begin
                        wr_idx_next  = '0;
                        rd_idx_next  = '0;
                        sec_idx_next = '0;
                        err_cnt_next = 16'd0;
                    end
                end
                default: begin
                end
            endcase
            if (err_inc && (err_cnt_reg != ERR_MAX)) begin
                err_cnt_next = err_cnt_reg + 16'd1;
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk_50m) begin
        if (!reset_n) begin
            wr_idx_reg  <= '0;
            rd_idx_reg  <= '0;
            sec_idx_reg <= '0;
            err_cnt_reg <= 16'd0;
        end else begin
            wr_idx_reg  <= wr_idx_next;
            rd_idx_reg  <= rd_idx_next;
            sec_idx_reg <= sec_idx_next;
            err_cnt_reg <= err_cnt_next;
        end
    end

    assign wr_start_en = wr_start_en_reg;
    assign rd_start_en = rd_start_en_reg;
    assign wr_sec_addr = wr_sec_addr_reg;
    assign rd_sec_addr = rd_sec_addr_reg;
    assign wr_data     = wr_pat;
    assign done        = done_reg;
    assign err_cnt     = err_cnt_reg;
    // Pass only once every word has been read back cleanly.
    assign error_flag  = ~(done_reg && (err_cnt_reg == 16'd0) && (rd_idx_reg == TOTAL_IDX));

endmodule

// File: tb/tb_sd_spi_multisec_test.sv
// Testbench for sd_spi_multisec_test: two instances (defaults, and
// PATTERN=1 / SEC_CNT=2 / START_ADDR=FFFF_FFFF) driven by a behavioural SD
// engine with random pacing; written words are stored in a card model and
// echoed back on reads.
`timescale 1ns/1ps
module tb_sd_spi_multisec_test;

    localparam int DATA_W = 16;
    localparam int WPS    = 256;
    localparam int NDUT   = 2;
    localparam int LOG_N  = 64;

    logic              clk_50m = 1'b0;
    logic              reset_n;
    logic              sd_init_done [NDUT];
    logic              test_start   [NDUT];
    logic              wr_busy      [NDUT];
    logic              wr_req       [NDUT];
    logic              wr_start_en  [NDUT];
    logic [31:0]       wr_sec_addr  [NDUT];
    logic [DATA_W-1:0] wr_data      [NDUT];
    logic              rd_busy      [NDUT];
    logic              rd_en        [NDUT];
    logic [DATA_W-1:0] rd_data      [NDUT];
    logic              rd_start_en  [NDUT];
    logic [31:0]       rd_sec_addr  [NDUT];
    logic              done         [NDUT];
    logic [15:0]       err_cnt      [NDUT];
    logic              error_flag   [NDUT];

    int checks = 0;
    int fails  = 0;

    logic [DATA_W-1:0] card   [NDUT][0:1023];
    logic [31:0]       wr_log [NDUT][0:LOG_N-1];
    logic [31:0]       rd_log [NDUT][0:LOG_N-1];
    int                wr_cnt [NDUT] = '{0, 0};
    int                rd_cnt [NDUT] = '{0, 0};

    always #10 clk_50m = ~clk_50m;

    sd_spi_multisec_test u_dut0 (
        .clk_50m      (clk_50m),
        .reset_n      (reset_n),
        .sd_init_done (sd_init_done[0]),
        .test_start   (test_start[0]),
        .wr_busy      (wr_busy[0]),
        .wr_req       (wr_req[0]),
        .wr_start_en  (wr_start_en[0]),
        .wr_sec_addr  (wr_sec_addr[0]),
        .wr_data      (wr_data[0]),
        .rd_busy      (rd_busy[0]),
        .rd_en        (rd_en[0]),
        .rd_data      (rd_data[0]),
        .rd_start_en  (rd_start_en[0]),
        .rd_sec_addr  (rd_sec_addr[0]),
        .done         (done[0]),
        .err_cnt      (err_cnt[0]),
        .error_flag   (error_flag[0])
    );

    sd_spi_multisec_test #(
        .SEC_CNT    (2),
        .START_ADDR (32'hFFFF_FFFF),
        .PATTERN    (1)
    ) u_dut1 (
        .clk_50m      (clk_50m),
        .reset_n      (reset_n),
        .sd_init_done (sd_init_done[1]),
        .test_start   (test_start[1]),
        .wr_busy      (wr_busy[1]),
        .wr_req       (wr_req[1]),
        .wr_start_en  (wr_start_en[1]),
        .wr_sec_addr  (wr_sec_addr[1]),
        .wr_data      (wr_data[1]),
        .rd_busy      (rd_busy[1]),
        .rd_en        (rd_en[1]),
        .rd_data      (rd_data[1]),
        .rd_start_en  (rd_start_en[1]),
        .rd_sec_addr  (rd_sec_addr[1]),
        .done         (done[1]),
        .err_cnt      (err_cnt[1]),
        .error_flag   (error_flag[1])
    );

    // Reference model: per-instance configuration and expected word values
    function automatic int sec_count(input int k);
        return (k == 0) ? 4 : 2;
    endfunction

    function automatic logic [31:0] base_addr(input int k);
        return (k == 0) ? 32'd2000 : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [DATA_W-1:0] ref_word(input int k, input int idx);
        logic [DATA_W-1:0] w;
        w = DATA_W'(idx);
        return (k == 0) ? w : ~w;
    endfunction

    // Log every start pulse with its address, sampled on the falling edge
    always @(negedge clk_50m) begin
        for (int k = 0; k < NDUT; k++) begin
            if (wr_start_en[k] === 1'b1) begin
                if (wr_cnt[k] < LOG_N) wr_log[k][wr_cnt[k]] <= wr_sec_addr[k];
                wr_cnt[k] <= wr_cnt[k] + 1;
            end
            if (rd_start_en[k] === 1'b1) begin
                if (rd_cnt[k] < LOG_N) rd_log[k][rd_cnt[k]] <= rd_sec_addr[k];
                rd_cnt[k] <= rd_cnt[k] + 1;
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_50m);
        #1;
    endtask

    // Write engine model for one sector, with spurious traffic on unrelated inputs
    task automatic write_sector(input int k, input int sec, input bit extra_wr);
        int waited;
        int base;
        int total;
        base   = sec * WPS;
        total  = sec_count(k) * WPS;
        waited = 0;
        while (wr_start_en[k] !== 1'b1 && waited < 40) begin
            tick();
            waited++;
        end
        checks++;
        if (wr_start_en[k] !== 1'b1) begin
            fails++;
            $display("FAIL wr_start_wait dut%0d sec %0d: no pulse in %0d cycles, required one", k, sec, waited);
            return;
        end
        $display("dut%0d write sector %0d addr %h", k, sec, wr_sec_addr[k]);
        wr_busy[k] = 1'b1;
        repeat ($urandom_range(0, 3)) tick();
        for (int i = 0; i < WPS; i++) begin
            wr_req[k]     = 1'b0;
            rd_en[k]      = 1'b0;
            rd_busy[k]    = 1'b0;
            test_start[k] = 1'b0;
            if ($urandom_range(0, 3) == 0) tick();
            rd_busy[k]    = (i == 10);
            rd_en[k]      = (i == 20);
            rd_data[k]    = DATA_W'($urandom);
            test_start[k] = (i == 30);
            wr_req[k]     = 1'b1;
            checks++;
            if (wr_data[k] !== ref_word(k, base + i)) begin
                fails++;
                $display("FAIL wr_data dut%0d word %0d: got %h, required %h", k, base + i, wr_data[k], ref_word(k, base + i));
            end
            card[k][base + i] = wr_data[k];
            tick();
        end
        wr_req[k]     = 1'b0;
        rd_en[k]      = 1'b0;
        rd_busy[k]    = 1'b0;
        test_start[k] = 1'b0;
        if (extra_wr) begin
            checks++;
            if (wr_data[k] !== ref_word(k, total)) begin
                fails++;
                $display("FAIL wr_data_end dut%0d: got %h, required %h", k, wr_data[k], ref_word(k, total));
            end
            wr_req[k] = 1'b1;
            tick();
            wr_req[k] = 1'b0;
            checks++;
            if (wr_data[k] !== ref_word(k, total)) begin
                fails++;
                $display("FAIL wr_data_sat dut%0d: got %h, required %h", k, wr_data[k], ref_word(k, total));
            end
        end
        wr_busy[k] = 1'b0;
        tick();
    endtask

    // Read engine model for one sector: echoes the card, optionally corrupting one word
    task automatic read_sector(input int k, input int sec, input int inject, input bit extra_rd);
        int waited;
        int base;
        base   = sec * WPS;
        waited = 0;
        while (rd_start_en[k] !== 1'b1 && waited < 40) begin
            tick();
            waited++;
        end
        checks++;
        if (rd_start_en[k] !== 1'b1) begin
            fails++;
            $display("FAIL rd_start_wait dut%0d sec %0d: no pulse in %0d cycles, required one", k, sec, waited);
            return;
        end
        $display("dut%0d read sector %0d addr %h", k, sec, rd_sec_addr[k]);
        rd_busy[k] = 1'b1;
        repeat ($urandom_range(0, 3)) tick();
        for (int i = 0; i < WPS; i++) begin
            rd_en[k]   = 1'b0;
            wr_req[k]  = 1'b0;
            rd_data[k] = DATA_W'($urandom);
            if ($urandom_range(0, 3) == 0) tick();
            wr_req[k]  = (i == 40);
            rd_en[k]   = 1'b1;
            rd_data[k] = card[k][base + i];
            if (base + i == inject) rd_data[k] = rd_data[k] ^ 16'h0001;
            tick();
        end
        rd_en[k]  = 1'b0;
        wr_req[k] = 1'b0;
        if (extra_rd) begin
            rd_en[k]   = 1'b1;
            rd_data[k] = ref_word(k, sec_count(k) * WPS);
            tick();
            rd_en[k]   = 1'b0;
        end
        rd_busy[k] = 1'b0;
        tick();
    endtask

    // One complete run, checked against the expected pulses, addresses and verdict
    task automatic run_full(input int k, input int inject, input bit extra);
        int          n;
        int          wr0;
        int          rd0;
        int          exp_err;
        logic [31:0] a;
        n   = sec_count(k);
        wr0 = wr_cnt[k];
        rd0 = rd_cnt[k];
        for (int s = 0; s < n; s++) write_sector(k, s, extra && (s == n - 1));
        checks++;
        if (done[k] !== 1'b0) begin
            fails++;
            $display("FAIL done_mid dut%0d: got %b, required 0", k, done[k]);
        end
        checks++;
        if (error_flag[k] !== 1'b1) begin
            fails++;
            $display("FAIL error_flag_mid dut%0d: got %b, required 1", k, error_flag[k]);
        end
        for (int s = 0; s < n; s++) read_sector(k, s, inject, extra && (s == n - 1));
        tick();
        tick();
        checks++;
        if (wr_cnt[k] - wr0 != n) begin
            fails++;
            $display("FAIL wr_pulses dut%0d: got %0d, required %0d", k, wr_cnt[k] - wr0, n);
        end
        checks++;
        if (rd_cnt[k] - rd0 != n) begin
            fails++;
            $display("FAIL rd_pulses dut%0d: got %0d, required %0d", k, rd_cnt[k] - rd0, n);
        end
        for (int s = 0; s < n; s++) begin
            a = base_addr(k) + 32'(s);
            checks++;
            if (wr_log[k][wr0 + s] !== a) begin
                fails++;
                $display("FAIL wr_addr dut%0d sec %0d: got %h, required %h", k, s, wr_log[k][wr0 + s], a);
            end
            checks++;
            if (rd_log[k][rd0 + s] !== a) begin
                fails++;
                $display("FAIL rd_addr dut%0d sec %0d: got %h, required %h", k, s, rd_log[k][rd0 + s], a);
            end
        end
        exp_err = ((inject >= 0 && inject < n * WPS) ? 1 : 0) + (extra ? 1 : 0);
        checks++;
        if (done[k] !== 1'b1) begin
            fails++;
            $display("FAIL done_end dut%0d: got %b, required 1", k, done[k]);
        end
        checks++;
        if (err_cnt[k] !== 16'(exp_err)) begin
            fails++;
            $display("FAIL err_cnt dut%0d: got %0d, required %0d", k, err_cnt[k], exp_err);
        end
        checks++;
        if (error_flag[k] !== (exp_err != 0)) begin
            fails++;
            $display("FAIL error_flag_end dut%0d: got %b, required %b", k, error_flag[k], exp_err != 0);
        end
        $display("dut%0d run complete: done=%b err_cnt=%0d error_flag=%b", k, done[k], err_cnt[k], error_flag[k]);
    endtask

    // Re-run request in DONE: status must clear on the next edge
    task automatic pulse_start(input int k);
        test_start[k] = 1'b1;
        tick();
        test_start[k] = 1'b0;
        checks++;
        if (done[k] !== 1'b0) begin
            fails++;
            $display("FAIL rerun_done dut%0d: got %b, required 0", k, done[k]);
        end
        checks++;
        if (err_cnt[k] !== 16'd0) begin
            fails++;
            $display("FAIL rerun_err_cnt dut%0d: got %0d, required 0", k, err_cnt[k]);
        end
        checks++;
        if (error_flag[k] !== 1'b1) begin
            fails++;
            $display("FAIL rerun_error_flag dut%0d: got %b, required 1", k, error_flag[k]);
        end
        $display("dut%0d re-run requested", k);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        for (int k = 0; k < NDUT; k++) begin
            checks++;
            if (wr_start_en[k] !== 1'b0 || rd_start_en[k] !== 1'b0) begin
                fails++;
                $display("FAIL reset_start dut%0d: got wr=%b rd=%b, required 0 0", k, wr_start_en[k], rd_start_en[k]);
            end
            checks++;
            if (wr_sec_addr[k] !== 32'd0 || rd_sec_addr[k] !== 32'd0) begin
                fails++;
                $display("FAIL reset_addr dut%0d: got wr=%h rd=%h, required 0 0", k, wr_sec_addr[k], rd_sec_addr[k]);
            end
            checks++;
            if (done[k] !== 1'b0) begin
                fails++;
                $display("FAIL reset_done dut%0d: got %b, required 0", k, done[k]);
            end
            checks++;
            if (err_cnt[k] !== 16'd0) begin
                fails++;
                $display("FAIL reset_err_cnt dut%0d: got %0d, required 0", k, err_cnt[k]);
            end
            checks++;
            if (error_flag[k] !== 1'b1) begin
                fails++;
                $display("FAIL reset_error_flag dut%0d: got %b, required 1", k, error_flag[k]);
            end
            checks++;
            if (wr_data[k] !== ref_word(k, 0)) begin
                fails++;
                $display("FAIL reset_wr_data dut%0d: got %h, required %h", k, wr_data[k], ref_word(k, 0));
            end
        end
        reset_n = 1'b1;
        tick();
        $display("reset checked");
    endtask

    task automatic test_ideal_run();
        sd_init_done[0] = 1'b1;
        run_full(0, -1, 1'b0);
    endtask

    task automatic test_read_error();
        pulse_start(0);
        run_full(0, 300, 1'b0);
    endtask

    task automatic test_back_to_back();
        pulse_start(0);
        run_full(0, -1, 1'b0);
    endtask

    task automatic test_abort();
        int waited;
        int wr0;
        int rd0;
        pulse_start(0);
        write_sector(0, 0, 1'b0);
        write_sector(0, 1, 1'b0);
        waited = 0;
        while (wr_start_en[0] !== 1'b1 && waited < 40) begin
            tick();
            waited++;
        end
        checks++;
        if (wr_start_en[0] !== 1'b1) begin
            fails++;
            $display("FAIL abort_wr_start dut0: no pulse in %0d cycles, required one", waited);
        end
        wr_busy[0] = 1'b1;
        for (int i = 0; i < 50; i++) begin
            wr_req[0] = 1'b1;
            tick();
        end
        wr_req[0]       = 1'b0;
        sd_init_done[0] = 1'b0;
        tick();
        tick();
        $display("dut0 init dropped in sector 2");
        checks++;
        if (done[0] !== 1'b0 || err_cnt[0] !== 16'd0) begin
            fails++;
            $display("FAIL abort_status dut0: got done=%b err=%0d, required 0 0", done[0], err_cnt[0]);
        end
        checks++;
        if (error_flag[0] !== 1'b1) begin
            fails++;
            $display("FAIL abort_error_flag dut0: got %b, required 1", error_flag[0]);
        end
        checks++;
        if (wr_data[0] !== ref_word(0, 0)) begin
            fails++;
            $display("FAIL abort_wr_data dut0: got %h, required %h", wr_data[0], ref_word(0, 0));
        end
        wr_busy[0] = 1'b0;
        wr0 = wr_cnt[0];
        rd0 = rd_cnt[0];
        repeat (6) tick();
        checks++;
        if (wr_cnt[0] != wr0 || rd_cnt[0] != rd0) begin
            fails++;
            $display("FAIL abort_pulses dut0: got %0d new pulses, required 0", (wr_cnt[0] - wr0) + (rd_cnt[0] - rd0));
        end
        sd_init_done[0] = 1'b1;
        run_full(0, -1, 1'b0);
    endtask

    task automatic test_pattern_wrap();
        int wr0;
        int rd0;
        wr0 = wr_cnt[1];
        rd0 = rd_cnt[1];
        sd_init_done[1] = 1'b1;
        run_full(1, -1, 1'b0);
        checks++;
        if (card[1][0] !== 16'hFFFF) begin
            fails++;
            $display("FAIL pattern_word0 dut1: got %h, required FFFF", card[1][0]);
        end
        checks++;
        if (card[1][5] !== 16'hFFFA) begin
            fails++;
            $display("FAIL pattern_word5 dut1: got %h, required FFFA", card[1][5]);
        end
        checks++;
        if (wr_log[1][wr0] !== 32'hFFFF_FFFF || wr_log[1][wr0 + 1] !== 32'h0000_0000) begin
            fails++;
            $display("FAIL wrap_wr_addr dut1: got %h %h, required FFFFFFFF 00000000", wr_log[1][wr0], wr_log[1][wr0 + 1]);
        end
        checks++;
        if (rd_log[1][rd0] !== 32'hFFFF_FFFF || rd_log[1][rd0 + 1] !== 32'h0000_0000) begin
            fails++;
            $display("FAIL wrap_rd_addr dut1: got %h %h, required FFFFFFFF 00000000", rd_log[1][rd0], rd_log[1][rd0 + 1]);
        end
    endtask

    task automatic test_extra_read();
        pulse_start(1);
        run_full(1, -1, 1'b1);
    endtask

    initial begin
        for (int k = 0; k < NDUT; k++) begin
            sd_init_done[k] = 1'b0;
            test_start[k]   = 1'b0;
            wr_busy[k]      = 1'b0;
            wr_req[k]       = 1'b0;
            rd_busy[k]      = 1'b0;
            rd_en[k]        = 1'b0;
            rd_data[k]      = '0;
        end
        reset_n = 1'b0;
        test_reset();
        test_ideal_run();
        test_read_error();
        test_back_to_back();
        test_abort();
        test_pattern_wrap();
        test_extra_read();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
